// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencing controller: host byte handshake into the data register/FIFO,
// FIFO pop and shifter load per frame, baud divisor ownership and frame counting.
//
// Write FSM
//   state  | meaning
//   W_IDLE | ready for a host byte (unless FIFO full)
//   W_CAP  | busy low, data register captures data_out
//   W_PUSH | write_en high, byte pushed into the FIFO
// Read FSM
//   state  | meaning
//   R_IDLE | waiting for tx_en and a non-empty FIFO
//   R_POP  | read_en high
//   R_LOAD | load high, FIFO output moves into the shifter
//   R_WAIT | frame on the line, waiting for done
module uart_tx_ctrl #(
   parameter logic [15:0] BRD_RESET = 16'd325
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tx_valid,
   input  logic [7:0]  tx_data,
   output logic        tx_ready,
   input  logic        tx_en,
   input  logic        cfg_we,
   input  logic [15:0] cfg_brd,
   input  logic        fifo_empty,
   input  logic        fifo_full,
   input  logic        done,
   output logic [7:0]  data_out,
   output logic        busy,
   output logic        write_en,
   output logic        read_en,
   output logic        load,
   output logic [15:0] brd,
   output logic        tx_idle,
   output logic        cfg_err,
   output logic [15:0] frames_sent
);

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_CAP  = 2'd1;
   localparam logic [1:0] W_PUSH = 2'd2;

   localparam logic [1:0] R_IDLE = 2'd0;
   localparam logic [1:0] R_POP  = 2'd1;
   localparam logic [1:0] R_LOAD = 2'd2;
   localparam logic [1:0] R_WAIT = 2'd3;

   logic [1:0] w_state, w_nxt;
   logic [1:0] r_state, r_nxt;
   logic       accept;

   // Gated by rst so no handshake can complete while the block is held in reset.
   assign tx_ready = rst & (w_state == W_IDLE) & ~fifo_full;
   assign accept   = tx_valid & tx_ready;

   always_comb begin
      w_nxt = w_state;
      case (w_state)
         W_IDLE:  if (accept) w_nxt = W_CAP;
         W_CAP:   w_nxt = W_PUSH;
         W_PUSH:  w_nxt = W_IDLE;
         default: w_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      r_nxt = r_state;
      case (r_state)
         R_IDLE:  if (tx_en && !fifo_empty) r_nxt = R_POP;
         R_POP:   r_nxt = R_LOAD;
         R_LOAD:  r_nxt = R_WAIT;
         R_WAIT:  if (done) r_nxt = R_IDLE;
         default: r_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         w_state     <= W_IDLE;
         r_state     <= R_IDLE;
         data_out    <= 8'h00;
         busy        <= 1'b1;
         write_en    <= 1'b0;
         read_en     <= 1'b0;
         load        <= 1'b0;
         brd         <= BRD_RESET;
         tx_idle     <= 1'b1;
         cfg_err     <= 1'b0;
         frames_sent <= 16'd0;
      end else begin
         w_state  <= w_nxt;
         r_state  <= r_nxt;
         busy     <= (w_nxt != W_CAP);
         write_en <= (w_nxt == W_PUSH);
         read_en  <= (r_nxt == R_POP);
         load     <= (r_nxt == R_LOAD);
         if (accept)
            data_out <= tx_data;
         if (r_state == R_WAIT && done)
            frames_sent <= frames_sent + 16'd1;
         // A push landing on this edge means the FIFO flag is stale, so it is not idle.
         tx_idle <= (w_nxt == W_IDLE) && (r_nxt == R_IDLE) && fifo_empty && !write_en;
         cfg_err <= cfg_we & ~tx_idle;
         if (cfg_we && tx_idle)
            brd <= cfg_brd;
      end
   end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Sequencing controller for the UART transmit datapath (data register → FIFO → shift register). It accepts bytes from a host through a valid/ready handshake and drives the datapath's `busy`, `write_en`, `read_en` and `load` strobes. It owns the 16-bit baud-rate divisor `brd` and reports frame status. It sits between the bus-side UART register block and the transmitter top.

## Interface
- `BRD_RESET`, default 16'd325: reset value of the baud divisor (50 MHz, 16x oversampling, 9600 baud).
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-low reset (0 = reset, sampled on the `clk` rising edge).
- `tx_valid`  in  1  host offers a byte.
- `tx_data`  in  8  host byte, valid while `tx_valid`=1.
- `tx_ready`  out  1  controller accepts the byte this cycle.
- `tx_en`  in  1  transmit enable; 0 pauses the start of new frames.
- `cfg_we`  in  1  single-cycle request to load `cfg_brd`.
- `cfg_brd`  in  16  new baud divisor.
- `fifo_empty`, `fifo_full`  in  1 each  datapath FIFO flags.
- `done`  in  1  one-cycle pulse from the shift register at the end of the stop bit.
- `data_out`  out  8  byte to datapath `data_in`.
- `busy`  out  1  data register hold; 0 for exactly one cycle to capture `data_out`.
- `write_en`, `read_en`, `load`  out  1 each  FIFO push, FIFO pop and shifter load strobes.
- `brd`  out  16  baud divisor to the shift register.
- `tx_idle`  out  1  1 when nothing is queued or in flight.
- `cfg_err`  out  1  one-cycle pulse when `cfg_we` is rejected.
- `frames_sent`  out  16  count of completed frames; wraps.

## Operation
- **Write FSM (W_IDLE, W_CAP, W_PUSH).** Each state except W_IDLE lasts one cycle.
  - W_IDLE: `tx_ready` = (`fifo_full`==0). On `tx_valid & tx_ready`, latch `tx_data` into `data_out` and go to W_CAP.
  - W_CAP: `busy`=0, so the data register captures `data_out`. Go to W_PUSH.
  - W_PUSH: `write_en`=1. Return to W_IDLE.
  - `tx_ready`=0 in W_CAP and W_PUSH. Maximum accept rate is one byte per 3 cycles.
- **Read FSM (R_IDLE, R_POP, R_LOAD, R_WAIT).**
  - R_IDLE: if `tx_en` & !`fifo_empty`, go to R_POP.
  - R_POP: `read_en`=1 for one cycle.
  - R_LOAD: `load`=1 for one cycle. The FIFO output is valid this cycle.
  - R_WAIT: hold until `done`=1. Then increment `frames_sent` and return to R_IDLE.
  - `done` outside R_WAIT is ignored.
- **Concurrency.** The two FSMs run independently. `write_en` and `read_en` may be high in the same cycle; the FIFO handles a simultaneous push and pop.
- **Pause.** `tx_en`=0 never aborts a frame; R_POP/R_LOAD/R_WAIT always complete. Bytes can still be queued while paused.
- **Idle flag.** `tx_idle` = W_IDLE & R_IDLE & `fifo_empty`, registered.
- **Configuration.** `cfg_we` is accepted only when `tx_idle`=1; `brd` ← `cfg_brd` at the next edge. Otherwise `brd` is unchanged and `cfg_err` pulses for 1 cycle. Writing 0 is accepted and passed through unchanged.
- **Counter.** `frames_sent` wraps from 16'hFFFF to 0.

## Timing
- **Reset values:**
  - `tx_ready`=0, `busy`=1, `write_en`=`read_en`=`load`=0.
  - `data_out`=8'h00, `brd`=`BRD_RESET`, `tx_idle`=1, `cfg_err`=0, `frames_sent`=0.
  - Both FSMs in their IDLE states.
- **Reset mid-operation:** all state returns to the reset values at the next edge, with no further strobes. The datapath is reset by the same `rst`, so a partial frame is discarded.
- **Write latency:** handshake at edge k → `busy`=0 in cycle k+1, `write_en`=1 in cycle k+2, `tx_ready` may be high again in cycle k+3.
- **Read latency:** `fifo_empty` seen low in R_IDLE at cycle n → `read_en` in n+1, `load` in n+2, R_WAIT from n+3.
- **Frame completion:** `done` at cycle m → `frames_sent` updates at m+1; the next `read_en` can occur at m+2 at the earliest.
- **Full boundary:** `fifo_full`=1 forces `tx_ready`=0 in the same cycle (combinational from the flag and state). No push is issued while full.
- **Empty boundary:** no `read_en` is issued while `fifo_empty`=1.
- **All strobes** are registered, glitch-free, single-cycle.

## Test plan
- **Single byte:** reset, then `tx_valid` with 8'hA5 →
  - `busy` low 1 cycle, then `write_en` 1 cycle;
  - `read_en`, then `load` on the following cycles;
  - after a `done` pulse, `frames_sent`=1 and `tx_idle`=1.
- **Burst to full:** hold `tx_valid` with `tx_en`=0 and a FIFO of depth 16 → exactly 16 accepts, spaced 3 cycles apart. `tx_ready` stays 0 once `fifo_full`=1, with no `write_en` while full.
- **Pause/resume:** drop `tx_en` during R_WAIT → the current frame completes with no new `read_en`. Raise `tx_en` → the next `read_en` follows within 1 cycle.
- **Config guard:**
  - `cfg_we` with `cfg_brd`=16'd27 while idle → `brd`=27 at the next edge.
  - The same request during R_WAIT → `brd` unchanged, `cfg_err` pulses once.
- **Reset mid-frame:** drive `rst`=0 in R_WAIT → all outputs at reset values on the next edge, `brd`=325. A `done` pulse after reset does not change `frames_sent`.
- **Wrap:** force 65536 `done` completions (or preload the counter via hierarchical force) → `frames_sent` returns to 0.
